// File: rtl/hazard_ctrl.sv
// Pipeline hazard/stall controller: flush, bubble, stall and bypass selects for the 5-stage core.
// Optional miss-timeout fault is enabled by defining HAZARD_MISS_TIMEOUT_EN.
module hazard_ctrl #(
  parameter logic [7:0] MISS_LIMIT = 8'd255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mode,
  input  logic        i_hit,
  input  logic        d_req,
  input  logic        d_hit,
  input  logic        jump,
  input  logic [3:0]  id_src1,
  input  logic [3:0]  id_src2,
  input  logic        id_use1,
  input  logic        id_use2,
  input  logic [3:0]  ex_src1,
  input  logic [3:0]  ex_src2,
  input  logic [3:0]  ex_dst,
  input  logic        ex_wr,
  input  logic        ex_load,
  input  logic [3:0]  mem_dst,
  input  logic        mem_wr,
  input  logic [3:0]  wb_dst,
  input  logic        wb_wr,
  output logic        stall_fe,
  output logic        stall_all,
  output logic        flush_if,
  output logic        bubble_id,
  output logic [1:0]  fwd_a,
  output logic [1:0]  fwd_b,
  output logic [15:0] stall_cnt,
  output logic        fault
);

  typedef enum logic [1:0] {RUN, IMISS, DMISS, FAULT} state_t;

  state_t      state, state_nxt;
  logic        d_miss;
  logic        load_use;
  logic        in_fault;
  logic [15:0] stall_cnt_q;

  assign d_miss   = d_req & ~d_hit;
  assign in_fault = (state == FAULT);
  assign load_use = ex_load & ex_wr & (ex_dst != 4'd0) &
                    ((id_use1 & (id_src1 == ex_dst)) | (id_use2 & (id_src2 == ex_dst)));

  // EX/MEM has the younger result, so it wins over MEM/WB; r0 never forwards.
  function automatic logic [1:0] fwd_sel(input logic [3:0] src,
                                         input logic mwr, input logic [3:0] mdst,
                                         input logic wwr, input logic [3:0] wdst);
    if (mwr && mdst != 4'd0 && mdst == src)
      return 2'b01;
    else if (wwr && wdst != 4'd0 && wdst == src)
      return 2'b10;
    else
      return 2'b00;
  endfunction

`ifdef HAZARD_MISS_TIMEOUT_EN
  logic [7:0] miss_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n)
      miss_cnt <= 8'd0;
    else if (state == IMISS || state == DMISS)
      miss_cnt <= miss_cnt + 8'd1;
    else
      miss_cnt <= 8'd0;
  end
`else
  logic unused_miss_limit;
  assign unused_miss_limit = ^MISS_LIMIT;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n)
      state <= RUN;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = RUN;
    if (in_fault)
      state_nxt = FAULT;
    else if (!mode)
      state_nxt = RUN;
    else if (d_miss)
      state_nxt = DMISS;
    else if (state == DMISS)
      state_nxt = RUN;
    else if (jump)
      state_nxt = RUN;
    else if (!i_hit)
      state_nxt = IMISS;
`ifdef HAZARD_MISS_TIMEOUT_EN
    // A miss that would persist past the limit escalates to the sticky fault.
    if (!in_fault && (state == IMISS || state == DMISS) &&
        state_nxt == state && miss_cnt == MISS_LIMIT)
      state_nxt = FAULT;
`endif
  end

  always_comb begin
    stall_fe  = 1'b0;
    stall_all = 1'b0;
    flush_if  = 1'b0;
    bubble_id = 1'b0;
    fwd_a     = 2'b00;
    fwd_b     = 2'b00;
    if (!rst_n) begin
      flush_if  = 1'b1;
      bubble_id = 1'b1;
    end else begin
      fwd_a = fwd_sel(ex_src1, mem_wr, mem_dst, wb_wr, wb_dst);
      fwd_b = fwd_sel(ex_src2, mem_wr, mem_dst, wb_wr, wb_dst);
      if (in_fault) begin
        stall_all = 1'b1;
        stall_fe  = 1'b1;
        flush_if  = 1'b1;
        bubble_id = 1'b1;
      end else if (!mode) begin
        stall_fe  = 1'b1;
        flush_if  = 1'b1;
        bubble_id = 1'b1;
      end else if (d_miss) begin
        stall_all = 1'b1;
        stall_fe  = 1'b1;
      end else if (jump) begin
        flush_if  = 1'b1;
        bubble_id = 1'b1;
      end else if (load_use) begin
        stall_fe  = 1'b1;
        bubble_id = 1'b1;
      end else if (!i_hit) begin
        stall_fe  = 1'b1;
        flush_if  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n)
      stall_cnt_q <= 16'd0;
    else if ((stall_fe | stall_all) && stall_cnt_q != 16'hFFFF)
      stall_cnt_q <= stall_cnt_q + 16'd1;
  end

  assign stall_cnt = rst_n ? stall_cnt_q : 16'd0;
  assign fault     = rst_n & in_fault;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl; the timeout scenario follows HAZARD_MISS_TIMEOUT_EN.
module tb_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mode, i_hit, d_req, d_hit, jump;
  logic [3:0]  id_src1, id_src2, ex_src1, ex_src2, ex_dst, mem_dst, wb_dst;
  logic        id_use1, id_use2, ex_wr, ex_load, mem_wr, wb_wr;
  logic        stall_fe, stall_all, flush_if, bubble_id, fault;
  logic [1:0]  fwd_a, fwd_b;
  logic [15:0] stall_cnt;

  int checks = 0;
  int failures = 0;

  hazard_ctrl #(.MISS_LIMIT(8'd4)) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .i_hit(i_hit), .d_req(d_req),
    .d_hit(d_hit), .jump(jump), .id_src1(id_src1), .id_src2(id_src2),
    .id_use1(id_use1), .id_use2(id_use2), .ex_src1(ex_src1), .ex_src2(ex_src2),
    .ex_dst(ex_dst), .ex_wr(ex_wr), .ex_load(ex_load), .mem_dst(mem_dst),
    .mem_wr(mem_wr), .wb_dst(wb_dst), .wb_wr(wb_wr), .stall_fe(stall_fe),
    .stall_all(stall_all), .flush_if(flush_if), .bubble_id(bubble_id),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .stall_cnt(stall_cnt), .fault(fault)
  );

  always #5 clk = ~clk;

  // Control vector order: {stall_fe, stall_all, flush_if, bubble_id}
  function automatic logic [3:0] ctl();
    return {stall_fe, stall_all, flush_if, bubble_id};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    mode = 1'b1; i_hit = 1'b1; d_req = 1'b0; d_hit = 1'b1; jump = 1'b0;
    id_src1 = 4'd0; id_src2 = 4'd0; id_use1 = 1'b0; id_use2 = 1'b0;
    ex_src1 = 4'd0; ex_src2 = 4'd0; ex_dst = 4'd0; ex_wr = 1'b0; ex_load = 1'b0;
    mem_dst = 4'd0; mem_wr = 1'b0; wb_dst = 4'd0; wb_wr = 1'b0;
  endtask

  task automatic do_reset();
    set_idle();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    set_idle();
    rst_n = 1'b0;
    mem_wr = 1'b1; mem_dst = 4'd5; ex_src1 = 4'd5;
    repeat (3) tick();
    checks++;
    if (ctl() !== 4'b0011) begin
      failures++; $display("[TB] FAIL reset_ctl got=%b exp=0011", ctl());
    end
    checks++;
    if (fwd_a !== 2'b00 || fault !== 1'b0 || stall_cnt !== 16'd0) begin
      failures++; $display("[TB] FAIL reset_regs got fwd_a=%b fault=%b cnt=%0d exp 00/0/0", fwd_a, fault, stall_cnt);
    end
    rst_n = 1'b1;
    set_idle();
    #1;
    checks++;
    if (ctl() !== 4'b0000) begin
      failures++; $display("[TB] FAIL release_ctl got=%b exp=0000", ctl());
    end
  endtask

  task automatic test_load_use();
    do_reset();
    ex_load = 1'b1; ex_wr = 1'b1; ex_dst = 4'd3; id_src1 = 4'd3; id_use1 = 1'b1;
    #1;
    checks++;
    if (ctl() !== 4'b1001) begin
      failures++; $display("[TB] FAIL load_use_stall got=%b exp=1001", ctl());
    end
    tick();
    // load moved to MEM; consumer now in EX reading r3
    ex_load = 1'b0; ex_wr = 1'b0; ex_dst = 4'd0; id_src1 = 4'd0; id_use1 = 1'b0;
    mem_wr = 1'b1; mem_dst = 4'd3; ex_src1 = 4'd3;
    #1;
    checks++;
    if (ctl() !== 4'b0000 || fwd_a !== 2'b01) begin
      failures++; $display("[TB] FAIL load_use_release got ctl=%b fwd_a=%b exp 0000/01", ctl(), fwd_a);
    end
    checks++;
    if (stall_cnt !== 16'd1) begin
      failures++; $display("[TB] FAIL load_use_cnt got=%0d exp=1", stall_cnt);
    end
    set_idle();
    ex_load = 1'b1; ex_wr = 1'b1; ex_dst = 4'd0; id_src1 = 4'd0; id_use1 = 1'b1;
    #1;
    checks++;
    if (ctl() !== 4'b0000) begin
      failures++; $display("[TB] FAIL load_use_r0 got=%b exp=0000", ctl());
    end
    ex_dst = 4'd7; id_src2 = 4'd7; id_use2 = 1'b1; id_src1 = 4'd1;
    #1;
    checks++;
    if (ctl() !== 4'b1001) begin
      failures++; $display("[TB] FAIL load_use_src2 got=%b exp=1001", ctl());
    end
    id_use2 = 1'b0;
    #1;
    checks++;
    if (ctl() !== 4'b0000) begin
      failures++; $display("[TB] FAIL load_use_unused got=%b exp=0000", ctl());
    end
    set_idle();
  endtask

  task automatic test_forwarding();
    do_reset();
    mem_dst = 4'd5; wb_dst = 4'd5; mem_wr = 1'b1; wb_wr = 1'b1; ex_src1 = 4'd5; ex_src2 = 4'd5;
    #1;
    checks++;
    if (fwd_a !== 2'b01 || fwd_b !== 2'b01) begin
      failures++; $display("[TB] FAIL fwd_both got a=%b b=%b exp 01/01", fwd_a, fwd_b);
    end
    mem_wr = 1'b0;
    #1;
    checks++;
    if (fwd_a !== 2'b10 || fwd_b !== 2'b10) begin
      failures++; $display("[TB] FAIL fwd_wb got a=%b b=%b exp 10/10", fwd_a, fwd_b);
    end
    wb_dst = 4'd0; ex_src2 = 4'd0; mem_wr = 1'b1; mem_dst = 4'd9; ex_src1 = 4'd9;
    #1;
    checks++;
    if (fwd_a !== 2'b01 || fwd_b !== 2'b00) begin
      failures++; $display("[TB] FAIL fwd_r0 got a=%b b=%b exp 01/00", fwd_a, fwd_b);
    end
    // bypass selects stay live during a full-pipe stall
    d_req = 1'b1; d_hit = 1'b0;
    #1;
    checks++;
    if (fwd_a !== 2'b01 || ctl() !== 4'b1100) begin
      failures++; $display("[TB] FAIL fwd_in_stall got a=%b ctl=%b exp 01/1100", fwd_a, ctl());
    end
    set_idle();
  endtask

  task automatic test_mode_off();
    do_reset();
    mode = 1'b0; d_req = 1'b1; d_hit = 1'b0; jump = 1'b1;
    #1;
    checks++;
    if (ctl() !== 4'b1011) begin
      failures++; $display("[TB] FAIL mode_off got=%b exp=1011", ctl());
    end
    set_idle();
  endtask

  task automatic test_jump_imiss();
    do_reset();
    i_hit = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++;
      if (ctl() !== 4'b1010) begin
        failures++; $display("[TB] FAIL imiss_%0d got=%b exp=1010", i, ctl());
      end
      tick();
    end
    jump = 1'b1;
    #1;
    checks++;
    if (ctl() !== 4'b0011) begin
      failures++; $display("[TB] FAIL jump_over_imiss got=%b exp=0011", ctl());
    end
    tick();
    set_idle();
    #1;
    checks++;
    if (ctl() !== 4'b0000 || stall_cnt !== 16'd2) begin
      failures++; $display("[TB] FAIL after_jump got ctl=%b cnt=%0d exp 0000/2", ctl(), stall_cnt);
    end
  endtask

  task automatic test_dmiss_jump();
    do_reset();
    d_req = 1'b1; d_hit = 1'b0; jump = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if (ctl() !== 4'b1100) begin
        failures++; $display("[TB] FAIL dmiss_%0d got=%b exp=1100", i, ctl());
      end
      tick();
    end
    checks++;
    if (stall_cnt !== 16'd4) begin
      failures++; $display("[TB] FAIL dmiss_cnt got=%0d exp=4", stall_cnt);
    end
    d_hit = 1'b1;
    #1;
    checks++;
    if (ctl() !== 4'b0011) begin
      failures++; $display("[TB] FAIL dmiss_hit_jump got=%b exp=0011", ctl());
    end
    tick();
    set_idle();
    #1;
    checks++;
    if (ctl() !== 4'b0000 || stall_cnt !== 16'd4) begin
      failures++; $display("[TB] FAIL after_dmiss got ctl=%b cnt=%0d exp 0000/4", ctl(), stall_cnt);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    i_hit = 1'b0;
`ifdef HAZARD_MISS_TIMEOUT_EN
    // first edge enters IMISS, five IMISS cycles follow, the sixth edge lands in FAULT
    for (int i = 1; i <= 5; i++) begin
      tick();
      checks++;
      if (fault !== 1'b0) begin
        failures++; $display("[TB] FAIL timeout_early_%0d got=%b exp=0", i, fault);
      end
    end
    tick();
    checks++;
    if (fault !== 1'b1 || ctl() !== 4'b1111) begin
      failures++; $display("[TB] FAIL timeout_fault got fault=%b ctl=%b exp 1/1111", fault, ctl());
    end
    i_hit = 1'b1; mode = 1'b0; jump = 1'b1;
    repeat (3) tick();
    checks++;
    if (fault !== 1'b1 || ctl() !== 4'b1111) begin
      failures++; $display("[TB] FAIL fault_sticky got fault=%b ctl=%b exp 1/1111", fault, ctl());
    end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    set_idle();
    #1;
    checks++;
    if (fault !== 1'b0 || ctl() !== 4'b0000) begin
      failures++; $display("[TB] FAIL fault_cleared got fault=%b ctl=%b exp 0/0000", fault, ctl());
    end
`else
    repeat (10) tick();
    checks++;
    if (fault !== 1'b0 || ctl() !== 4'b1010 || stall_cnt !== 16'd10) begin
      failures++; $display("[TB] FAIL no_timeout got fault=%b ctl=%b cnt=%0d exp 0/1010/10", fault, ctl(), stall_cnt);
    end
    // reset mid-miss leaves nothing behind
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    set_idle();
    #1;
    checks++;
    if (ctl() !== 4'b0000 || stall_cnt !== 16'd0) begin
      failures++; $display("[TB] FAIL reset_mid_miss got ctl=%b cnt=%0d exp 0000/0", ctl(), stall_cnt);
    end
`endif
    set_idle();
  endtask

  initial begin
    set_idle();
    rst_n = 1'b0;
    test_reset();
    test_load_use();
    test_forwarding();
    test_mode_off();
    test_jump_imiss();
    test_dmiss_jump();
    test_timeout();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard and stall controller for the 16-bit five-stage core. It sequences the IF-stage instruction zeroing, the IF/ID flush, the ID/EX bubble and the EX-stage operand bypass selects. It also freezes the pipe on I- and D-cache misses. It sits beside the pipeline registers and drives only their enable, flush and select controls; it touches no datapath values.

## Interface
- MISS_LIMIT, 255: miss cycles allowed before fault (8-bit); used only with the timeout macro.

- clk  in  1  core clock
- rst_n  in  1  synchronous active-low reset
- mode  in  1  1 = run; 0 = core held, NOPs injected
- i_hit  in  1  I-cache hit for current fetch
- d_req  in  1  MEM-stage instruction accesses memory
- d_hit  in  1  D-cache hit
- jump  in  1  EX-stage redirect taken
- id_src1, id_src2  in  4  ID-stage source register numbers
- id_use1, id_use2  in  1  ID source actually read
- ex_src1, ex_src2  in  4  EX-stage source register numbers
- ex_dst  in  4  EX destination; ex_wr in 1 writes; ex_load in 1 is a load
- mem_dst  in  4  EX/MEM destination; mem_wr in 1
- wb_dst  in  4  MEM/WB destination; wb_wr in 1
- stall_fe  out  1  hold PC and IF/ID
- stall_all  out  1  hold every pipeline register
- flush_if  out  1  IF/ID loads NOP (0x0000)
- bubble_id  out  1  ID/EX loads NOP
- fwd_a, fwd_b  out  2  00 register file, 01 EX/MEM result, 10 MEM/WB result
- stall_cnt  out  16  saturating count of stall cycles
- fault  out  1  miss timeout fault; sticky

## Operation
- Register r0 is constant zero. A destination of 0 never forwards and never creates a load-use hazard.
- States: RUN, IMISS, DMISS, FAULT. FAULT exists only with the macro. The state register updates on posedge clk.
- Output priority, highest first:
  1. FAULT: stall_all = stall_fe = flush_if = bubble_id = 1.
  2. mode = 0: stall_fe = flush_if = bubble_id = 1, stall_all = 0.
  3. D-miss (d_req & ~d_hit): stall_all = stall_fe = 1, flush_if = bubble_id = 0.
  4. jump: flush_if = bubble_id = 1, stall_fe = 0 so the PC loads the target. Jump cancels any I-miss or load-use stall.
  5. load-use: ex_load & ex_wr & ex_dst ≠ 0 & ((id_use1 & id_src1 == ex_dst) | (id_use2 & id_src2 == ex_dst)). Drives stall_fe = bubble_id = 1.
  6. I-miss (~i_hit): stall_fe = flush_if = 1.
  7. Otherwise all four outputs = 0.
- Next state:
  - mode = 0 → RUN.
  - D-miss → DMISS.
  - jump → RUN.
  - ~i_hit → IMISS.
  - Otherwise → RUN.
  - From DMISS: d_hit → RUN, and any pending I-miss is re-evaluated in RUN.
- Forwarding for fwd_a (fwd_b identical on ex_src2):
  - 01 if mem_wr & mem_dst ≠ 0 & mem_dst == ex_src1.
  - Else 10 if wb_wr & wb_dst ≠ 0 & wb_dst == ex_src1.
  - Else 00.
  - EX/MEM wins when both match. Forwarding is computed in every state, including stalls.
- stall_cnt increments each cycle that stall_fe | stall_all = 1, and saturates at 0xFFFF.

## Timing
- All control outputs are combinational from state and the current inputs, and act in the same cycle.
- State and counters are registered.
- Reset (rst_n = 0 at posedge) sets state RUN and clears stall_cnt, fault and the miss counter.
- While rst_n = 0, outputs are: flush_if = bubble_id = 1, stall_fe = stall_all = 0, fwd = 00, stall_cnt = 0, fault = 0.
- Reset asserted mid-miss abandons the miss with no residue.
- Load-use stall lasts exactly 1 cycle: the load advances to MEM and then forwards via 01.
- Miss stalls last until the hit cycle inclusive of the miss cycles. Pipeline advance resumes on the hit cycle.

## Configuration
- HAZARD_MISS_TIMEOUT_EN defined:
  - An 8-bit miss counter increments each cycle in IMISS or DMISS and clears on any other state.
  - When the counter equals MISS_LIMIT and the miss condition still holds, the next state is FAULT.
  - FAULT sets fault = 1 and holds until reset; mode and jump are ignored.
- Undefined: no miss counter, fault tied to 0, and FAULT is unreachable.

## Test plan
- Reset: hold rst_n = 0 for 3 cycles → flush_if = bubble_id = 1, fault = 0, stall_cnt = 0. Release with all hits → all stall/flush outputs 0.
- Load-use: ex_load = ex_wr = 1, ex_dst = 3, id_src1 = 3, id_use1 = 1 → stall_fe = bubble_id = 1 for exactly 1 cycle. With ex_dst = 0 instead → no stall.
- Forwarding: mem_dst = wb_dst = 5, both writing, ex_src1 = 5 → fwd_a = 01. Then mem_wr = 0 → fwd_a = 10.
- Jump during I-miss: i_hit = 0 for 2 cycles, then jump = 1 with i_hit still 0 → that cycle stall_fe = 0, flush_if = bubble_id = 1, and the next state is RUN.
- D-miss over jump: d_req = 1, d_hit = 0 and jump = 1 for 4 cycles → stall_all = 1, bubble_id = 0 throughout, stall_cnt = 4. On d_hit, jump takes effect.
- Timeout (macro on, MISS_LIMIT = 4): i_hit = 0 held → fault = 1 after 5 miss cycles and stays 1 with i_hit = 1 and mode = 0 until rst_n = 0.
